// File: rtl/gmii_tx_arbiter.sv
// Two-requester round-robin arbiter for one GMII TX port: grants whole frames,
// enforces the inter-frame gap, truncates over-long frames and times out idle grants.
module gmii_tx_arbiter #(
  parameter int unsigned IFG_LEN  = 12,
  parameter int unsigned MAX_LEN  = 1526,
  parameter int unsigned START_TO = 64
) (
  input  logic       gmii_tx_clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req0_tx_en,
  input  logic [7:0] req0_txd,
  output logic       grant0,
  input  logic       req1,
  input  logic       req1_tx_en,
  input  logic [7:0] req1_txd,
  output logic       grant1,
  output logic       gmii_tx_en,
  output logic [7:0] gmii_txd,
  output logic       busy,
  output logic       err_len,
  output logic       err_to
);

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned BCNT_W  = 11;
  localparam int unsigned CNT_MAX = (START_TO > IFG_LEN) ? START_TO : IFG_LEN;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_XMIT,
    S_IFG
  } state_t;

  state_t              state, state_n;
  logic                sel, sel_n;
  logic                last_served, last_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [BCNT_W-1:0]   byte_cnt, byte_cnt_n;
  logic                grant0_n, grant1_n;
  logic                tx_en_n;
  logic [DATA_W-1:0]   txd_n;
  logic                busy_n, err_len_n, err_to_n;

  logic                sel_tx_en;
  logic [DATA_W-1:0]   sel_txd;
  logic                pick;

  // Only the granted requester's byte stream is ever looked at.
  assign sel_tx_en = sel ? req1_tx_en : req0_tx_en;
  assign sel_txd   = sel ? req1_txd   : req0_txd;

  // On a tie the requester that was not served last wins.
  assign pick = (req0 && req1) ? ~last_served : req1;

  // State register and registered outputs.
  always_ff @(posedge gmii_tx_clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      sel         <= 1'b0;
      last_served <= 1'b1;
      cnt         <= '0;
      byte_cnt    <= '0;
      grant0      <= 1'b0;
      grant1      <= 1'b0;
      gmii_tx_en  <= 1'b0;
      gmii_txd    <= '0;
      busy        <= 1'b0;
      err_len     <= 1'b0;
      err_to      <= 1'b0;
    end else begin
      state       <= state_n;
      sel         <= sel_n;
      last_served <= last_n;
      cnt         <= cnt_n;
      byte_cnt    <= byte_cnt_n;
      grant0      <= grant0_n;
      grant1      <= grant1_n;
      gmii_tx_en  <= tx_en_n;
      gmii_txd    <= txd_n;
      busy        <= busy_n;
      err_len     <= err_len_n;
      err_to      <= err_to_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n    = state;
    sel_n      = sel;
    last_n     = last_served;
    cnt_n      = cnt;
    byte_cnt_n = byte_cnt;
    grant0_n   = grant0;
    grant1_n   = grant1;
    tx_en_n    = 1'b0;
    txd_n      = '0;
    err_len_n  = 1'b0;
    err_to_n   = 1'b0;

    unique case (state)
      S_IDLE: begin
        grant0_n = 1'b0;
        grant1_n = 1'b0;
        if (req0 || req1) begin
          state_n    = S_GRANT;
          sel_n      = pick;
          cnt_n      = '0;
          byte_cnt_n = '0;
          grant0_n   = ~pick;
          grant1_n   = pick;
        end
      end

      S_GRANT: begin
        if (sel_tx_en) begin
          state_n    = S_XMIT;
          tx_en_n    = 1'b1;
          txd_n      = sel_txd;
          byte_cnt_n = BCNT_W'(1);
        end else if (cnt == CNT_W'(START_TO - 1)) begin
          state_n  = S_IDLE;
          grant0_n = 1'b0;
          grant1_n = 1'b0;
          err_to_n = 1'b1;
          last_n   = sel;
          cnt_n    = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      S_XMIT: begin
        if (!sel_tx_en) begin
          state_n  = S_IFG;
          grant0_n = 1'b0;
          grant1_n = 1'b0;
          last_n   = sel;
          cnt_n    = '0;
        end else if (byte_cnt == BCNT_W'(MAX_LEN)) begin
          // Frame hit the length limit: cut it here, the rest is dropped.
          state_n   = S_IFG;
          grant0_n  = 1'b0;
          grant1_n  = 1'b0;
          err_len_n = 1'b1;
          last_n    = sel;
          cnt_n     = '0;
        end else begin
          tx_en_n    = 1'b1;
          txd_n      = sel_txd;
          byte_cnt_n = byte_cnt + BCNT_W'(1);
        end
      end

      S_IFG: begin
        // Gap is counted from the first cycle gmii_tx_en is low.
        if (cnt == CNT_W'(IFG_LEN - 1)) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      default: state_n = S_IDLE;
    endcase

    busy_n = (state_n != S_IDLE);
  end

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// Scoreboard bench for gmii_tx_arbiter: drivers push expected grants/frames,
// a monitor reassembles GMII frames and checks them against those queues.
`timescale 1ns/1ps
module tb_gmii_tx_arbiter;

  localparam int IFG_LEN  = 12;
  localparam int MAX_LEN  = 1526;
  localparam int START_TO = 64;
  localparam int WAIT_MAX = 5000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_v;
  logic [1:0] ten_v;
  logic [7:0] txd_v [2];
  logic       grant0, grant1, gmii_tx_en, busy, err_len, err_to;
  logic [7:0] gmii_txd;

  gmii_tx_arbiter #(
    .IFG_LEN(IFG_LEN),
    .MAX_LEN(MAX_LEN),
    .START_TO(START_TO)
  ) dut (
    .gmii_tx_clk(clk),
    .rst_n(rst_n),
    .req0(req_v[0]),
    .req0_tx_en(ten_v[0]),
    .req0_txd(txd_v[0]),
    .grant0(grant0),
    .req1(req_v[1]),
    .req1_tx_en(ten_v[1]),
    .req1_txd(txd_v[1]),
    .grant1(grant1),
    .gmii_tx_en(gmii_tx_en),
    .gmii_txd(gmii_txd),
    .busy(busy),
    .err_len(err_len),
    .err_to(err_to)
  );

  always #4 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state and expectation queues
  int         exp_grant[$];
  int         exp_len[2][$];
  bit         exp_trunc[2][$];
  logic [7:0] exp_dat[2][$];
  int         m_last = 1;
  int         m_to = 0;
  int         m_trunc = 0;

  // Monitor observations
  int         seen_to = 0;
  int         seen_len = 0;
  int         n_abort = 0;
  int         mon_bytes = 0;
  bit         in_frame = 1'b0;
  bit         have_prev = 1'b0;
  bit         busy_track = 1'b0;
  int         owner = 0;
  int         low_run = 0;
  int         busy_run = 0;
  int         grant_run = 0;
  int         grant_bytes = 0;
  logic [1:0] g_prev = 2'b00;
  logic [7:0] cur[$];

  task automatic chk(input string name, input longint act, input longint expv);
    n_chk++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic fail_line(input string name, input longint act, input longint expv);
    n_chk++;
    n_err++;
    $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
  endtask

  function automatic logic gnt(input int id);
    return (id == 0) ? grant0 : grant1;
  endfunction

  // Round-robin decision from pending requests and who was served last.
  function automatic int rr_pick(input bit p0, input bit p1);
    if (p0 && p1) return (m_last == 0) ? 1 : 0;
    return p1 ? 1 : 0;
  endfunction

  task automatic model_grant(input int id, input int len);
    exp_grant.push_back(id);
    m_last = id;
    if (len == 0) m_to++;
    if (len > MAX_LEN) m_trunc++;
  endtask

  // Requester: raise req, wait for grant, then stream len bytes (len 0 = never start).
  task automatic send(input int id, input int len, input int pat, output int waited);
    logic [7:0] d[$];
    int elen;
    int w;
    for (int i = 0; i < len; i++) d.push_back((pat < 0) ? 8'($urandom) : 8'(pat));
    @(negedge clk);
    req_v[id] = 1'b1;
    waited = 0;
    while (!gnt(id) && waited < WAIT_MAX) begin
      @(negedge clk);
      waited++;
    end
    req_v[id] = 1'b0;
    if (!gnt(id)) begin
      fail_line("grant_wait_timeout", id, -1);
      return;
    end
    if (len == 0) begin
      w = 0;
      while (gnt(id) && w < START_TO + 8) begin
        @(negedge clk);
        w++;
      end
      if (gnt(id)) fail_line("grant_never_withdrawn", w, START_TO);
      return;
    end
    elen = (len > MAX_LEN) ? MAX_LEN : len;
    exp_len[id].push_back(elen);
    exp_trunc[id].push_back(len > MAX_LEN);
    for (int i = 0; i < elen; i++) exp_dat[id].push_back(d[i]);
    for (int i = 0; i < len; i++) begin
      if (!rst_n) break;
      ten_v[id] = 1'b1;
      txd_v[id] = d[i];
      @(negedge clk);
    end
    ten_v[id] = 1'b0;
    txd_v[id] = 8'h00;
  endtask

  task automatic single(input int id, input int len, input int pat, output int waited);
    model_grant(id, len);
    send(id, len, pat, waited);
  endtask

  task automatic pair(input int l0, input int l1);
    int p, w0, w1;
    p = rr_pick(1'b1, 1'b1);
    model_grant(p, (p == 0) ? l0 : l1);
    model_grant(1 - p, (p == 0) ? l1 : l0);
    fork
      send(0, l0, -1, w0);
      send(1, l1, -1, w1);
    join
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    repeat (2) @(negedge clk);
    while (busy && w < WAIT_MAX) begin
      @(negedge clk);
      w++;
    end
    if (busy) fail_line("idle_wait_timeout", w, WAIT_MAX);
  endtask

  task automatic close_frame(input bit aborted);
    int el, bad;
    bit tr;
    logic [7:0] e;
    if (exp_len[owner].size() == 0) begin
      fail_line("unexpected_frame_len", cur.size(), 0);
      return;
    end
    el = exp_len[owner].pop_front();
    tr = exp_trunc[owner].pop_front();
    bad = 0;
    for (int i = 0; i < el; i++) begin
      e = exp_dat[owner].pop_front();
      if (i < cur.size() && cur[i] != e) bad++;
    end
    if (aborted) begin
      n_abort++;
      chk("aborted_prefix_len_ok", (cur.size() > 0 && cur.size() <= el) ? 1 : 0, 1);
    end else begin
      chk("frame_len", cur.size(), el);
      chk("frame_err_len", err_len, tr);
    end
    chk("frame_data_mismatches", bad, 0);
  endtask

  // Monitor: samples 1ns after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        chk("reset_outputs", {gmii_tx_en, gmii_txd, grant0, grant1, busy, err_len, err_to}, 0);
        if (in_frame) close_frame(1'b1);
        cur.delete();
        in_frame = 1'b0;
        have_prev = 1'b0;
        busy_track = 1'b0;
        g_prev = 2'b00;
        grant_run = 0;
        grant_bytes = 0;
        mon_bytes = 0;
        low_run = 0;
      end else begin
        chk("grant_exclusive", grant0 & grant1, 0);
        chk("txd_zero_when_idle", (!gmii_tx_en && gmii_txd != 8'h00) ? 1 : 0, 0);
        chk("busy_when_granted", ((grant0 | grant1) && !busy) ? 1 : 0, 0);
        if (err_to) seen_to++;
        if (err_len) seen_len++;
        for (int id = 0; id < 2; id++) begin
          if (gnt(id) && !g_prev[id]) begin
            if (exp_grant.size() == 0) fail_line("grant_order_unexpected", id, -1);
            else chk("grant_order", id, exp_grant.pop_front());
            grant_run = 0;
            grant_bytes = 0;
          end
          if (!gnt(id) && g_prev[id]) begin
            if (grant_bytes == 0) begin
              chk("timeout_grant_cycles", grant_run, START_TO);
              chk("timeout_err_to", err_to, 1);
            end else begin
              chk("frame_err_to", err_to, 0);
            end
          end
        end
        if (grant0 | grant1) grant_run++;
        if (gmii_tx_en) begin
          if (!in_frame) begin
            in_frame = 1'b1;
            cur.delete();
            owner = grant1 ? 1 : 0;
            chk("frame_has_owner", grant0 | grant1, 1);
            if (have_prev)
              chk("ifg_min_low_cycles", (low_run >= IFG_LEN + 2) ? IFG_LEN + 2 : low_run, IFG_LEN + 2);
          end
          cur.push_back(gmii_txd);
          grant_bytes++;
          mon_bytes = cur.size();
        end else begin
          if (in_frame) begin
            close_frame(1'b0);
            in_frame = 1'b0;
            have_prev = 1'b1;
            low_run = 0;
            busy_track = 1'b1;
            busy_run = 0;
            mon_bytes = 0;
          end
          low_run++;
        end
        if (busy_track) begin
          if (busy) busy_run++;
          else begin
            chk("ifg_busy_cycles", busy_run, IFG_LEN);
            busy_track = 1'b0;
          end
        end
        g_prev = {grant1, grant0};
      end
    end
  end

  initial begin
    #2000000;
    fail_line("watchdog_expired", 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    int w;
    logic [1:0] mask;
    int l0, l1;
    rst_n = 1'b0;
    req_v = 2'b00;
    ten_v = 2'b00;
    txd_v[0] = 8'h00;
    txd_v[1] = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Single 60-byte frame of 0x55 from requester 0
    single(0, 60, 8'h55, w);
    chk("grant_latency", w, 1);

    // Both requesters continuously busy: grants alternate
    wait_idle();
    for (int i = 0; i < 6; i++) model_grant(rr_pick(1'b1, 1'b1), 64);
    fork
      begin repeat (3) send(0, 64, -1, w); end
      begin repeat (3) send(1, 64, -1, w); end
    join

    // Over-long frame is truncated
    wait_idle();
    single(1, 2000, -1, w);

    // Requester 0 never starts; pending requester 1 served next
    wait_idle();
    pair(0, 40);

    // Ungranted requester toggles tx_en with 0xAA
    wait_idle();
    model_grant(0, 50);
    fork
      send(0, 50, -1, w);
      begin
        for (int i = 0; i < 70; i++) begin
          @(negedge clk);
          ten_v[1] = ~ten_v[1];
          txd_v[1] = 8'hAA;
        end
        ten_v[1] = 1'b0;
        txd_v[1] = 8'h00;
      end
    join

    // Reset in the middle of a requester-1 frame
    wait_idle();
    model_grant(1, 60);
    fork
      send(1, 60, -1, w);
      begin
        int k;
        k = 0;
        while (mon_bytes < 30 && k < WAIT_MAX) begin
          @(negedge clk);
          k++;
        end
        if (mon_bytes < 30) fail_line("mid_frame_wait", mon_bytes, 30);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_last = 1;
      end
    join
    wait_idle();
    pair(30, 30);

    // Randomised rounds
    for (int r = 0; r < 25; r++) begin
      wait_idle();
      mask = 2'($urandom_range(1, 3));
      l0 = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 90));
      l1 = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 90));
      if (mask == 2'b11) pair(l0, l1);
      else if (mask[0]) single(0, l0, -1, w);
      else single(1, l1, -1, w);
    end

    wait_idle();
    repeat (20) @(negedge clk);
    chk("exp_grants_left", exp_grant.size(), 0);
    chk("exp_frames_left", exp_len[0].size() + exp_len[1].size(), 0);
    chk("err_to_pulses", seen_to, m_to);
    chk("err_len_pulses", seen_len, m_trunc);
    chk("aborted_frames", n_abort, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
